// File: rtl/fir_xifu_pkg.sv
// Shared types and default widths for the FIR XIF coprocessor MAC engine.
// Struct widths follow the package defaults below.
package fir_xifu_pkg;

    localparam int MAC_NB_LANES  = 4;
    localparam int MAC_DATA_W    = 16;
    localparam int MAC_COEFF_W   = 16;
    localparam int MAC_ACC_W     = 40;
    localparam int MAC_NB_ACC    = 4;
    localparam int MAC_ID_W      = 4;
    localparam int MAC_SHIFT_W   = 6;
    localparam int MAC_ACC_IDX_W = $clog2(MAC_NB_ACC);

    typedef enum logic [1:0] {
        MAC_CLR = 2'd0,
        MAC_MAC = 2'd1,
        MAC_SET = 2'd2,
        MAC_RDQ = 2'd3
    } fir_xifu_mac_op_e;

    typedef struct packed {
        fir_xifu_mac_op_e                      op;
        logic [MAC_ACC_IDX_W-1:0]              acc;
        logic [MAC_ID_W-1:0]                   id;
        logic [MAC_NB_LANES*MAC_DATA_W-1:0]    x;
        logic [MAC_NB_LANES*MAC_COEFF_W-1:0]   c;
        logic [MAC_SHIFT_W-1:0]                shift;
    } fir_xifu_mac_req_t;

    typedef struct packed {
        logic [MAC_ID_W-1:0] id;
        logic [31:0]         data;
        logic                sat;
    } fir_xifu_mac_rsp_t;

endpackage

// File: rtl/fir_xifu_simd_mac_if.sv
// Request/response handshake bundle between EX, the MAC engine and WB.
// The master side issues requests and accepts results; the engine is the slave.
interface fir_xifu_simd_mac_if
    import fir_xifu_pkg::*;
#(
    parameter int NB_LANES = MAC_NB_LANES,
    parameter int DATA_W   = MAC_DATA_W,
    parameter int COEFF_W  = MAC_COEFF_W,
    parameter int NB_ACC   = MAC_NB_ACC,
    parameter int ID_W     = MAC_ID_W
);

    logic                        clear_i;
    logic                        req_valid_i;
    logic                        req_ready_o;
    logic [1:0]                  req_op_i;
    logic [$clog2(NB_ACC)-1:0]   req_acc_i;
    logic [ID_W-1:0]             req_id_i;
    logic [NB_LANES*DATA_W-1:0]  req_x_i;
    logic [NB_LANES*COEFF_W-1:0] req_c_i;
    logic [MAC_SHIFT_W-1:0]      req_shift_i;
    logic                        rsp_valid_o;
    logic                        rsp_ready_i;
    logic [ID_W-1:0]             rsp_id_o;
    logic [31:0]                 rsp_data_o;
    logic                        rsp_sat_o;

    modport master (
        output clear_i, req_valid_i, req_op_i, req_acc_i,
        output req_id_i, req_x_i, req_c_i, req_shift_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_id_o,
        input  rsp_data_o, rsp_sat_o
    );

    modport slave (
        input  clear_i, req_valid_i, req_op_i, req_acc_i,
        input  req_id_i, req_x_i, req_c_i, req_shift_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_id_o,
        output rsp_data_o, rsp_sat_o
    );

endinterface

// File: rtl/fir_xifu_rdq_round.sv
// Accumulator read-out: round-half-up arithmetic right shift, then
// saturate to a signed 32-bit result with a saturation flag.
module fir_xifu_rdq_round
    import fir_xifu_pkg::*;
#(
    parameter int ACC_W = MAC_ACC_W
) (
    input  logic signed [ACC_W-1:0]       acc_i,
    input  logic        [MAC_SHIFT_W-1:0] shift_i,
    output logic        [31:0]            data_o,
    output logic                          sat_o
);

    // One guard bit so the rounding add can never wrap.
    localparam int W = ACC_W + 1;
    localparam logic signed [W-1:0] MAX_V = W'(64'sd2147483647);
    localparam logic signed [W-1:0] MIN_V = W'(-64'sd2147483648);

    logic signed [W-1:0] ext;
    logic signed [W-1:0] rnd;
    logic signed [W-1:0] t;

    always_comb begin
        ext = W'(acc_i);
        rnd = '0;
        if (shift_i != '0) begin
            rnd = W'(1) << (shift_i - MAC_SHIFT_W'(1));
        end
        t = (ext + rnd) >>> shift_i;
        data_o = t[31:0];
        sat_o  = 1'b0;
        if (t > MAX_V) begin
            data_o = 32'h7fff_ffff;
            sat_o  = 1'b1;
        end else if (t < MIN_V) begin
            data_o = 32'h8000_0000;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/fir_xifu_simd_mac.sv
// Multi-lane signed dot-product MAC engine with private wide accumulators.
// S1 registers lane products; S2 reduces them and applies the op in order.
module fir_xifu_simd_mac
    import fir_xifu_pkg::*;
#(
    parameter int NB_LANES = MAC_NB_LANES,
    parameter int DATA_W   = MAC_DATA_W,
    parameter int COEFF_W  = MAC_COEFF_W,
    parameter int ACC_W    = MAC_ACC_W,
    parameter int NB_ACC   = MAC_NB_ACC,
    parameter int ID_W     = MAC_ID_W
) (
    input logic                clk_i,
    input logic                rst_i,
    fir_xifu_simd_mac_if.slave bus
);

    localparam int PROD_W = DATA_W + COEFF_W;
    localparam int IDX_W  = $clog2(NB_ACC);

    logic                      s1_valid;
    logic signed [PROD_W-1:0]  s1_prod [NB_LANES];
    fir_xifu_mac_op_e          s1_op;
    logic [IDX_W-1:0]          s1_acc;
    logic [ID_W-1:0]           s1_id;
    logic [MAC_SHIFT_W-1:0]    s1_shift;

    logic                      s2_valid;
    logic signed [ACC_W-1:0]   s2_sum;
    fir_xifu_mac_op_e          s2_op;
    logic [IDX_W-1:0]          s2_acc;
    logic [ID_W-1:0]           s2_id;
    logic [MAC_SHIFT_W-1:0]    s2_shift;

    logic signed [ACC_W-1:0]   acc_q [NB_ACC];
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   cur;
    logic signed [ACC_W-1:0]   acc_nxt;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [31:0]               rsp_data;
    logic                      rsp_sat;
    logic [31:0]               rnd_data;
    logic                      rnd_sat;

    logic stall;
    logic accept;
    logic fire;

    // Only a pending read-out has to wait for the response slot.
    assign stall = rsp_valid & ~bus.rsp_ready_i
                 & s2_valid & (s2_op == MAC_RDQ);
    assign bus.req_ready_o = ~stall & ~bus.clear_i & ~rst_i;
    assign accept = bus.req_valid_i & bus.req_ready_o;
    assign fire   = s2_valid & ~stall & ~bus.clear_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int i = 0; i < NB_LANES; i++) begin
                s1_prod[i] <=
                    PROD_W'($signed(bus.req_x_i[i*DATA_W +: DATA_W]))
                  * PROD_W'($signed(bus.req_c_i[i*COEFF_W +: COEFF_W]));
            end
            s1_op    <= fir_xifu_mac_op_e'(bus.req_op_i);
            s1_acc   <= bus.req_acc_i;
            s1_id    <= bus.req_id_i;
            s1_shift <= bus.req_shift_i;
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NB_LANES; i++) begin
            sum = sum + ACC_W'(s1_prod[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            s2_valid <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!stall && s1_valid) begin
            s2_sum   <= sum;
            s2_op    <= s1_op;
            s2_acc   <= s1_acc;
            s2_id    <= s1_id;
            s2_shift <= s1_shift;
        end
    end

    always_comb begin
        cur     = acc_q[s2_acc];
        acc_nxt = cur;
        unique case (s2_op)
            MAC_CLR: acc_nxt = '0;
            MAC_MAC: acc_nxt = cur + s2_sum;
            MAC_SET: acc_nxt = s2_sum;
            MAC_RDQ: acc_nxt = cur;
        endcase
    end

    fir_xifu_rdq_round #(
        .ACC_W (ACC_W)
    ) u_round (
        .acc_i   (cur),
        .shift_i (s2_shift),
        .data_o  (rnd_data),
        .sat_o   (rnd_sat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NB_ACC; i++) begin
                acc_q[i] <= '0;
            end
        end else if (fire && s2_op != MAC_RDQ) begin
            acc_q[s2_acc] <= acc_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_sat   <= 1'b0;
        end else if (bus.clear_i) begin
            rsp_valid <= 1'b0;
        end else if (fire && s2_op == MAC_RDQ) begin
            rsp_valid <= 1'b1;
            rsp_id    <= s2_id;
            rsp_data  <= rnd_data;
            rsp_sat   <= rnd_sat;
        end else if (bus.rsp_ready_i) begin
            rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_id_o    = rsp_id;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.rsp_sat_o   = rsp_sat;

endmodule
